// File: rtl/fir_pkg.sv
// Shared definitions for the serial FIR control path.
// Contents:
//   seq_state_t     - tap sequencer FSM states
//   MAX_MAC_LATENCY - largest supported MAC pipeline depth
//   DRAIN_BITS      - width of the drain counter that covers MAX_MAC_LATENCY
//   count_bits()    - tap index width for a given tap count
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DRAIN,
    DONE
  } seq_state_t;

  localparam int unsigned MAX_MAC_LATENCY = 7;
  localparam int unsigned DRAIN_BITS      = 3;

  // A tap index is never narrower than one bit.
  function automatic int count_bits(input int taps);
    return (taps > 2) ? $clog2(taps) : 1;
  endfunction

endpackage

// File: rtl/fir_tap_counter.sv
// Modulo-NUMBER_OF_TAPS counter for the tap index.
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   en       - advance the count by one, wrapping after NUMBER_OF_TAPS-1
//   clear    - force the count to zero (wins over en)
//   count    - current tap index, always in 0..NUMBER_OF_TAPS-1
//   last     - count == NUMBER_OF_TAPS-1
module fir_tap_counter
  import fir_pkg::*;
#(
  parameter int NUMBER_OF_TAPS = 64,
  localparam int COUNTER_BITS = count_bits(NUMBER_OF_TAPS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clear,
  output logic [COUNTER_BITS-1:0] count,
  output logic                    last
);

  localparam logic [COUNTER_BITS-1:0] LastIdx = COUNTER_BITS'(NUMBER_OF_TAPS - 1);

  logic [COUNTER_BITS-1:0] count_q, count_d;

  assign last  = (count_q == LastIdx);
  assign count = count_q;

  // Explicit wrap at LastIdx keeps non-power-of-2 tap counts in range.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = last ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fir_tap_sequencer.sv
// Control sequencer for a single-MAC serial FIR.
// Accepts one sample per run (in_valid/in_ready), pulses phase_min to shift the delay
// line, sweeps current_count over all taps with acc_clear/acc_enable, waits MAC_LATENCY
// cycles for the MAC pipeline to drain, then holds out_valid until out_ready.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   in_valid       - source has a sample
//   in_ready       - sequencer is idle and can take a sample
//   phase_min      - in_valid & in_ready, delay line shift strobe
//   current_count  - tap index to delay-line mux and coefficient ROM
//   acc_clear      - first tap: accumulator loads instead of adding
//   acc_enable     - product at current_count is valid
//   out_valid      - accumulated result valid
//   out_ready      - sink accepts the result
//   busy           - not idle
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int NUMBER_OF_TAPS = 64,
  parameter int MAC_LATENCY    = 1,
  localparam int COUNTER_BITS = count_bits(NUMBER_OF_TAPS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    phase_min,
  output logic [COUNTER_BITS-1:0] current_count,
  output logic                    acc_clear,
  output logic                    acc_enable,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy
);

  if (NUMBER_OF_TAPS < 2) begin : g_bad_taps
    $error("NUMBER_OF_TAPS must be at least 2");
  end
  if (MAC_LATENCY < 0 || MAC_LATENCY > int'(MAX_MAC_LATENCY)) begin : g_bad_latency
    $error("MAC_LATENCY out of range");
  end

  // Final drain count; unused when MAC_LATENCY is 0 since DRAIN is then skipped.
  localparam logic [DRAIN_BITS-1:0] DrainLast =
      DRAIN_BITS'((MAC_LATENCY > 0) ? MAC_LATENCY - 1 : 0);

  seq_state_t            state_q;
  logic [DRAIN_BITS-1:0] drain_q;
  logic                  in_ready_q;
  logic                  acc_clear_q;
  logic                  acc_enable_q;
  logic                  out_valid_q;
  logic                  busy_q;

  logic                  cnt_en;
  logic                  cnt_clear;
  logic                  cnt_last;

  assign cnt_en    = (state_q == MAC);
  assign cnt_clear = (state_q == IDLE);

  fir_tap_counter #(
    .NUMBER_OF_TAPS(NUMBER_OF_TAPS)
  ) u_tap_counter (
    .clk  (clk),
    .rst  (rst),
    .en   (cnt_en),
    .clear(cnt_clear),
    .count(current_count),
    .last (cnt_last)
  );

  // Outputs are registered alongside the state so they change exactly with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      drain_q      <= '0;
      in_ready_q   <= 1'b1;
      acc_clear_q  <= 1'b0;
      acc_enable_q <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      acc_clear_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q      <= MAC;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b1;
            acc_enable_q <= 1'b1;
            acc_clear_q  <= 1'b1;
          end
        end
        MAC: begin
          if (cnt_last) begin
            acc_enable_q <= 1'b0;
            if (MAC_LATENCY > 0) begin
              state_q <= DRAIN;
              drain_q <= '0;
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drain_q == DrainLast) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign phase_min  = in_valid & in_ready_q;
  assign acc_clear  = acc_clear_q;
  assign acc_enable = acc_enable_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;

endmodule
